ap_fifo_frame_arbiter: RTL and testbench

AP_FIFO_FRAME_ARBITER -- requirements
Module: ap_fifo_frame_arbiter

---
 rtl/ap_arb_pkg.sv | 13 +
 rtl/arb_tag_fifo.sv | 64 ++++++
 rtl/ap_fifo_frame_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ap_fifo_frame_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ap_arb_pkg.sv
// Shared defaults and state encoding for the two-source HLS frame arbiter.
package ap_arb_pkg;

  localparam int unsigned AP_WIDTH     = 32;
  localparam int unsigned AP_FRAME_LEN = 16;
  localparam int unsigned AP_TAG_DEPTH = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FEED = 1'b1
  } state_e;

endpackage

// File: rtl/arb_tag_fifo.sv
// Small FIFO of 1-bit requester ids, one entry per frame inside the HLS core.
module arb_tag_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic pop_i,
  input  logic din_i,
  output logic head_o,
  output logic empty_o,
  output logic full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Push is refused only on the current-cycle full flag, even if a pop coincides.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/ap_fifo_frame_arbiter.sv
// Round-robin frame arbiter feeding an HLS core from two source FIFOs and
// routing its results back to the matching sink FIFO by per-frame tag.
module ap_fifo_frame_arbiter
  import ap_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = AP_WIDTH,
  parameter int unsigned FRAME_LEN = AP_FRAME_LEN,
  parameter int unsigned TAG_DEPTH = AP_TAG_DEPTH
) (
  input  logic             ip_clk,
  input  logic             ip_rst_n,
  input  logic [WIDTH-1:0] src0_dout,
  input  logic             src0_empty,
  output logic             src0_rd_en,
  input  logic [WIDTH-1:0] src1_dout,
  input  logic             src1_empty,
  output logic             src1_rd_en,
  input  logic [1:0]       src_en,
  output logic [WIDTH-1:0] in_V_V_dout,
  output logic             in_V_V_empty_n,
  input  logic             in_V_V_read,
  input  logic [WIDTH-1:0] out_V_V_din,
  output logic             out_V_V_full_n,
  input  logic             out_V_V_write,
  output logic [WIDTH-1:0] snk0_din,
  output logic             snk0_wr_en,
  input  logic             snk0_full,
  output logic [WIDTH-1:0] snk1_din,
  output logic             snk1_wr_en,
  input  logic             snk1_full,
  output logic             grant,
  output logic             busy,
  output logic             err
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] FRAME_END  = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             empty_n_q, empty_n_d;
  logic             err_q, err_d;

  logic tag_push, tag_pop, tag_head, tag_empty, tag_full;
  logic elig0, elig1, slot_free, rd_g;
  logic snk_full_h, full_n, accept;

  arb_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk_i   (ip_clk),
    .rst_ni  (ip_rst_n),
    .push_i  (tag_push),
    .pop_i   (tag_pop),
    .din_i   (grant_d),
    .head_o  (tag_head),
    .empty_o (tag_empty),
    .full_o  (tag_full)
  );

  assign elig0     = src_en[0] && !src0_empty;
  assign elig1     = src_en[1] && !src1_empty;
  assign slot_free = !empty_n_q || in_V_V_read;

  // Input side: pick a requester, then stream exactly one frame from it.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    issued_d = issued_q;
    tag_push = 1'b0;
    rd_g     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!tag_full && (elig0 || elig1)) begin
          grant_d  = (elig0 && elig1) ? !grant_q : elig1;
          tag_push = 1'b1;
          state_d  = ST_FEED;
        end
      end
      ST_FEED: begin
        rd_g = !(grant_q ? src1_empty : src0_empty) && (issued_q < FRAME_END) && slot_free;
        if (rd_g) begin
          issued_d = issued_q + CNT_W'(1);
        end
        if ((issued_q == FRAME_END) && slot_free) begin
          issued_d = '0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding slot toward the core; a read with a refill keeps it valid.
  always_comb begin
    empty_n_d = empty_n_q;
    if (rd_g) begin
      empty_n_d = 1'b1;
    end else if (in_V_V_read) begin
      empty_n_d = 1'b0;
    end
  end

  assign src0_rd_en     = ip_rst_n && rd_g && !grant_q;
  assign src1_rd_en     = ip_rst_n && rd_g && grant_q;
  assign in_V_V_dout    = grant_q ? src1_dout : src0_dout;
  assign in_V_V_empty_n = empty_n_q;

  // Output side: results go to the sink named by the oldest outstanding tag.
  assign snk_full_h     = tag_head ? snk1_full : snk0_full;
  assign full_n         = ip_rst_n && !tag_empty && !snk_full_h;
  assign accept         = out_V_V_write && full_n;
  assign out_V_V_full_n = full_n;
  assign snk0_wr_en     = accept && !tag_head;
  assign snk1_wr_en     = accept && tag_head;
  assign snk0_din       = out_V_V_din;
  assign snk1_din       = out_V_V_din;

  always_comb begin
    out_cnt_d = out_cnt_q;
    tag_pop   = 1'b0;
    err_d     = err_q;
    if (accept) begin
      if (out_cnt_q == FRAME_LAST) begin
        out_cnt_d = '0;
        tag_pop   = 1'b1;
      end else begin
        out_cnt_d = out_cnt_q + CNT_W'(1);
      end
    end
    if (out_V_V_write && !full_n) begin
      err_d = 1'b1;
    end
  end

  assign grant = grant_q;
  assign err   = err_q;
  assign busy  = (state_q == ST_FEED) || !tag_empty;

  always_ff @(posedge ip_clk) begin
    if (!ip_rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= 1'b0;
      issued_q  <= '0;
      out_cnt_q <= '0;
      empty_n_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      issued_q  <= issued_d;
      out_cnt_q <= out_cnt_d;
      empty_n_q <= empty_n_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_ap_fifo_frame_arbiter.sv
// Directed bench: behavioural source/sink FIFOs and a loopback HLS core model.
module tb_ap_fifo_frame_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned FL = 16;
  localparam int unsigned TD = 4;

  logic         ip_clk = 1'b0;
  logic         ip_rst_n;
  logic [W-1:0] src0_dout, src1_dout;
  logic         src0_empty, src1_empty, src0_rd_en, src1_rd_en;
  logic [1:0]   src_en;
  logic [W-1:0] in_V_V_dout;
  logic         in_V_V_empty_n, in_V_V_read;
  logic [W-1:0] out_V_V_din;
  logic         out_V_V_full_n, out_V_V_write;
  logic [W-1:0] snk0_din, snk1_din;
  logic         snk0_wr_en, snk1_wr_en, snk0_full, snk1_full;
  logic         grant, busy, err;

  always #5 ip_clk = ~ip_clk;

  ap_fifo_frame_arbiter #(
    .WIDTH     (W),
    .FRAME_LEN (FL),
    .TAG_DEPTH (TD)
  ) dut (
    .ip_clk         (ip_clk),
    .ip_rst_n       (ip_rst_n),
    .src0_dout      (src0_dout),
    .src0_empty     (src0_empty),
    .src0_rd_en     (src0_rd_en),
    .src1_dout      (src1_dout),
    .src1_empty     (src1_empty),
    .src1_rd_en     (src1_rd_en),
    .src_en         (src_en),
    .in_V_V_dout    (in_V_V_dout),
    .in_V_V_empty_n (in_V_V_empty_n),
    .in_V_V_read    (in_V_V_read),
    .out_V_V_din    (out_V_V_din),
    .out_V_V_full_n (out_V_V_full_n),
    .out_V_V_write  (out_V_V_write),
    .snk0_din       (snk0_din),
    .snk0_wr_en     (snk0_wr_en),
    .snk0_full      (snk0_full),
    .snk1_din       (snk1_din),
    .snk1_wr_en     (snk1_wr_en),
    .snk1_full      (snk1_full),
    .grant          (grant),
    .busy           (busy),
    .err            (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] src_q0[$], src_q1[$], core_q[$], snk_q0[$], snk_q1[$], in_log[$];
  bit           core_rd_en, core_wr_en, force_write;
  int           cyc, nreads, first_rd, last_rd;
  logic         s_rd0, s_rd1, s_wr0, s_wr1, s_read, s_acc;
  logic [W-1:0] s_dout, s_d0, s_d1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive core handshakes, sample strobes, then update the models.
  task automatic tick();
    logic rst_s;
    @(negedge ip_clk);
    in_V_V_read = core_rd_en && in_V_V_empty_n;
    #1;
    out_V_V_write = force_write || (core_wr_en && (core_q.size() > 0) && out_V_V_full_n);
    out_V_V_din   = (core_q.size() > 0) ? core_q[0] : W'(32'hDEAD_BEEF);
    #1;
    s_rd0  = src0_rd_en;
    s_rd1  = src1_rd_en;
    s_wr0  = snk0_wr_en;
    s_wr1  = snk1_wr_en;
    s_d0   = snk0_din;
    s_d1   = snk1_din;
    s_read = in_V_V_read;
    s_dout = in_V_V_dout;
    s_acc  = out_V_V_write && out_V_V_full_n;
    rst_s  = ip_rst_n;
    @(posedge ip_clk);
    #1;
    cyc++;
    if (s_rd0 && (src_q0.size() > 0)) src0_dout = src_q0.pop_front();
    if (s_rd1 && (src_q1.size() > 0)) src1_dout = src_q1.pop_front();
    src0_empty = (src_q0.size() == 0);
    src1_empty = (src_q1.size() == 0);
    if (rst_s) begin
      if (s_acc && (core_q.size() > 0)) void'(core_q.pop_front());
      if (s_read) begin
        core_q.push_back(s_dout);
        in_log.push_back(s_dout);
        nreads++;
        if (nreads == 1) first_rd = cyc;
        last_rd = cyc;
      end
    end
    if (s_wr0) snk_q0.push_back(s_d0);
    if (s_wr1) snk_q1.push_back(s_d1);
  endtask

  task automatic load(input int s, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      if (s == 0) src_q0.push_back(W'(base + i));
      else        src_q1.push_back(W'(base + i));
    end
    src0_empty = (src_q0.size() == 0);
    src1_empty = (src_q1.size() == 0);
  endtask

  task automatic do_reset();
    ip_rst_n = 1'b0;
    tick();
    check("rst_no_strobe", 64'({s_rd0, s_rd1, s_wr0, s_wr1}), 64'(0));
    core_q.delete();
    in_log.delete();
    snk_q0.delete();
    snk_q1.delete();
    nreads   = 0;
    ip_rst_n = 1'b1;
    check("rst_empty_n", 64'(in_V_V_empty_n), 64'(0));
    check("rst_full_n",  64'(out_V_V_full_n), 64'(0));
    check("rst_grant",   64'(grant), 64'(0));
    check("rst_busy",    64'(busy), 64'(0));
    check("rst_err",     64'(err), 64'(0));
  endtask

  task automatic run_until(input string tag, input int n0, input int n1, input int budget);
    int i;
    i = 0;
    while ((i < budget) && !((snk_q0.size() >= n0) && (snk_q1.size() >= n1))) begin
      tick();
      i++;
    end
    check({tag, "_done"}, 64'(i < budget), 64'(1));
  endtask

  task automatic chk_sink(input string tag, input int s, input int base, input int n);
    int sz;
    logic [W-1:0] v;
    sz = (s == 0) ? snk_q0.size() : snk_q1.size();
    check({tag, "_cnt"}, 64'(sz), 64'(n));
    for (int i = 0; (i < n) && (i < sz); i++) begin
      v = (s == 0) ? snk_q0[i] : snk_q1[i];
      check($sformatf("%s_w%0d", tag, i), 64'(v), 64'(base + i));
    end
  endtask

  initial begin
    ip_rst_n      = 1'b0;
    src0_dout     = '0;
    src1_dout     = '0;
    src0_empty    = 1'b1;
    src1_empty    = 1'b1;
    src_en        = 2'b11;
    in_V_V_read   = 1'b0;
    out_V_V_din   = '0;
    out_V_V_write = 1'b0;
    snk0_full     = 1'b0;
    snk1_full     = 1'b0;
    core_rd_en    = 1'b1;
    core_wr_en    = 1'b1;
    force_write   = 1'b0;
    cyc           = 0;
    nreads        = 0;
    first_rd      = 0;
    last_rd       = 0;

    do_reset();

    // Single frame from source 0 at full throughput
    load(0, 'h100, 16);
    run_until("t1", 16, 0, 200);
    check("t1_nreads", 64'(nreads), 64'(16));
    check("t1_span", 64'(last_rd - first_rd), 64'(15));
    for (int i = 0; i < 16; i++) check($sformatf("t1_in%0d", i), 64'(in_log[i]), 64'('h100 + i));
    chk_sink("t1_snk0", 0, 'h100, 16);
    check("t1_snk1_cnt", 64'(snk_q1.size()), 64'(0));
    repeat (3) tick();
    check("t1_busy_end", 64'(busy), 64'(0));

    // Both sources loaded: frames alternate 1,0,1,0
    do_reset();
    load(0, 'h100, 32);
    load(1, 'h200, 32);
    run_until("t2", 32, 32, 600);
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 16; i++)
        check($sformatf("t2_f%0d_w%0d", k, i), 64'(in_log[k*16+i]),
              64'(((k % 2) == 0 ? 'h200 : 'h100) + 16*(k/2) + i));
    chk_sink("t2_snk0", 0, 'h100, 32);
    chk_sink("t2_snk1", 1, 'h200, 32);

    // Core output stalled: only TAG_DEPTH frames may enter
    do_reset();
    load(0, 'h100, 48);
    load(1, 'h200, 48);
    core_wr_en = 1'b0;
    repeat (200) tick();
    check("t3_nreads_stall", 64'(nreads), 64'(TD * FL));
    check("t3_empty_n_stall", 64'(in_V_V_empty_n), 64'(0));
    check("t3_busy_stall", 64'(busy), 64'(1));
    check("t3_full_n_stall", 64'(out_V_V_full_n), 64'(1));
    core_wr_en = 1'b1;
    run_until("t3", 48, 48, 1500);
    check("t3_nreads", 64'(nreads), 64'(96));
    chk_sink("t3_snk0", 0, 'h100, 48);
    chk_sink("t3_snk1", 1, 'h200, 48);

    // Sink 1 backpressure holds results without loss
    do_reset();
    load(1, 'h200, 16);
    snk1_full = 1'b1;
    repeat (60) tick();
    check("t4_full_n", 64'(out_V_V_full_n), 64'(0));
    check("t4_snk1_held", 64'(snk_q1.size()), 64'(0));
    check("t4_nreads", 64'(nreads), 64'(16));
    snk1_full = 1'b0;
    run_until("t4", 0, 16, 100);
    chk_sink("t4_snk1", 1, 'h200, 16);
    check("t4_snk0_cnt", 64'(snk_q0.size()), 64'(0));
    check("t4_err", 64'(err), 64'(0));

    // Write with no frame outstanding is a sticky protocol error
    do_reset();
    force_write = 1'b1;
    tick();
    force_write = 1'b0;
    check("t5_no_wr", 64'({s_wr0, s_wr1}), 64'(0));
    check("t5_err", 64'(err), 64'(1));
    repeat (5) tick();
    check("t5_err_sticky", 64'(err), 64'(1));
    check("t5_snk_cnt", 64'(snk_q0.size() + snk_q1.size()), 64'(0));

    // Reset in the middle of a frame, then a clean frame
    do_reset();
    load(0, 'h100, 32);
    for (int i = 0; (i < 100) && (nreads < 7); i++) tick();
    check("t6_nreads_pre", 64'(nreads), 64'(7));
    check("t6_busy_pre", 64'(busy), 64'(1));
    do_reset();
    src_q0.delete();
    load(0, 'h300, 16);
    run_until("t6", 16, 0, 200);
    check("t6_nreads", 64'(nreads), 64'(16));
    for (int i = 0; i < 16; i++) check($sformatf("t6_in%0d", i), 64'(in_log[i]), 64'('h300 + i));
    chk_sink("t6_snk0", 0, 'h300, 16);
    check("t6_snk1_cnt", 64'(snk_q1.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
